// File: rtl/ysyx_24110006_exu_commit.sv
// ysyx_24110006_exu_commit
// Commit queue between the execute stage and write-back. Execute-stage
// entries are held in a small FIFO and the head entry is presented
// combinationally downstream. Load/store entries (i_mem=1) complete the
// upstream handshake but are not stored, since the LSU owns them. Popping a
// head that jumps/traps/branches squashes everything still queued; i_flush
// empties the queue unconditionally.
//
// Ports
//   i_clock, i_reset_n      clock, asynchronous active-low reset
//   i_alu_t .. i_mem        execute-stage entry fields
//   i_result, i_upc         ALU result and update PC
//   i_valid / o_ready       upstream handshake
//   o_valid / i_ready       downstream handshake
//   i_flush                 pipeline kill
//   o_upc .. o_jump         head-entry fields (enables/jump gated by o_valid)
//   o_count                 number of stored entries
module ysyx_24110006_exu_commit #(
    parameter int XLEN  = 32,
    parameter int RD_W  = 5,
    parameter int DEPTH = 2
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    input  logic [3:0]               i_alu_t,
    input  logic [RD_W-1:0]          i_reg_rd,
    input  logic                     i_cmp,
    input  logic                     i_zero,
    input  logic                     i_result_t,
    input  logic                     i_reg_wen,
    input  logic                     i_csr_wen,
    input  logic                     i_jump,
    input  logic                     i_trap,
    input  logic                     i_mem,
    input  logic [XLEN-1:0]          i_result,
    input  logic [XLEN-1:0]          i_upc,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic                     o_valid,
    input  logic                     i_ready,
    input  logic                     i_flush,
    output logic [XLEN-1:0]          o_upc,
    output logic [XLEN-1:0]          o_result,
    output logic [RD_W-1:0]          o_reg_rd,
    output logic                     o_result_t,
    output logic                     o_reg_wen,
    output logic                     o_csr_wen,
    output logic                     o_jump,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 4 + RD_W + 7 + 2 * XLEN;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [EW-1:0]   r_mem [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    logic            w_ready;
    logic            w_valid;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic            w_redirect;
    logic            w_branch;
    logic            w_jump;
    logic [EW-1:0]   w_in;

    logic [3:0]      w_h_alu_t;
    logic [RD_W-1:0] w_h_rd;
    logic            w_h_cmp;
    logic            w_h_zero;
    logic            w_h_result_t;
    logic            w_h_reg_wen;
    logic            w_h_csr_wen;
    logic            w_h_jump;
    logic            w_h_trap;
    logic [XLEN-1:0] w_h_result;
    logic [XLEN-1:0] w_h_upc;

    // Handshake depends only on occupancy, never on i_ready.
    assign w_ready    = (r_count < DEPTH_C);
    assign w_valid    = (r_count != '0);
    assign w_accept   = i_valid && w_ready && !i_flush;
    assign w_push     = w_accept && !i_mem;
    assign w_pop      = w_valid && i_ready;
    assign w_redirect = w_pop && w_jump;

    assign w_in = {i_alu_t, i_reg_rd, i_cmp, i_zero, i_result_t, i_reg_wen,
                   i_csr_wen, i_jump, i_trap, i_result, i_upc};

    assign {w_h_alu_t, w_h_rd, w_h_cmp, w_h_zero, w_h_result_t, w_h_reg_wen,
            w_h_csr_wen, w_h_jump, w_h_trap, w_h_result, w_h_upc} = r_mem[r_head];

    always_comb begin
        w_branch = 1'b0;
        case (w_h_alu_t)
            4'b1000:          w_branch = w_h_zero;
            4'b1001:          w_branch = !w_h_zero;
            4'b1100, 4'b1110: w_branch = w_h_cmp;
            4'b1101, 4'b1111: w_branch = !w_h_cmp;
            default:          w_branch = 1'b0;
        endcase
    end

    assign w_jump = w_valid && (w_h_trap || w_h_jump || w_branch);

    // Payload is not reset; a write that lands during a redirect is harmless
    // because the pointers are cleared in the same edge.
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_tail] <= w_in;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush || w_redirect) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_ready    = w_ready;
    assign o_valid    = w_valid;
    assign o_upc      = w_h_upc;
    assign o_result   = w_h_result;
    assign o_reg_rd   = w_h_rd;
    assign o_result_t = w_h_result_t;
    assign o_reg_wen  = w_valid && w_h_reg_wen;
    assign o_csr_wen  = w_valid && w_h_csr_wen;
    assign o_jump     = w_jump;
    assign o_count    = r_count;

endmodule

// File: tb/tb_ysyx_24110006_exu_commit.sv
module tb_ysyx_24110006_exu_commit;

    localparam int XLEN  = 32;
    localparam int RD_W  = 5;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            i_clock = 1'b0;
    logic            i_reset_n;
    logic [3:0]      i_alu_t;
    logic [RD_W-1:0] i_reg_rd;
    logic            i_cmp, i_zero, i_result_t, i_reg_wen, i_csr_wen;
    logic            i_jump, i_trap, i_mem;
    logic [XLEN-1:0] i_result, i_upc;
    logic            i_valid, o_ready, o_valid, i_ready, i_flush;
    logic [XLEN-1:0] o_upc, o_result;
    logic [RD_W-1:0] o_reg_rd;
    logic            o_result_t, o_reg_wen, o_csr_wen, o_jump;
    logic [CW-1:0]   o_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  alu_t;
        logic [4:0]  rd;
        bit          cmp, zero, result_t, reg_wen, csr_wen, jump, trap;
        logic [31:0] result, upc;
    } ent_t;

    ent_t q[$];

    always #5 i_clock = ~i_clock;

    ysyx_24110006_exu_commit #(.XLEN(XLEN), .RD_W(RD_W), .DEPTH(DEPTH)) dut (
        .i_clock(i_clock), .i_reset_n(i_reset_n),
        .i_alu_t(i_alu_t), .i_reg_rd(i_reg_rd), .i_cmp(i_cmp), .i_zero(i_zero),
        .i_result_t(i_result_t), .i_reg_wen(i_reg_wen), .i_csr_wen(i_csr_wen),
        .i_jump(i_jump), .i_trap(i_trap), .i_mem(i_mem),
        .i_result(i_result), .i_upc(i_upc),
        .i_valid(i_valid), .o_ready(o_ready), .o_valid(o_valid), .i_ready(i_ready),
        .i_flush(i_flush),
        .o_upc(o_upc), .o_result(o_result), .o_reg_rd(o_reg_rd),
        .o_result_t(o_result_t), .o_reg_wen(o_reg_wen), .o_csr_wen(o_csr_wen),
        .o_jump(o_jump), .o_count(o_count)
    );

    function automatic bit takes_branch(ent_t e);
        case (e.alu_t)
            4'b1000:          return e.zero;
            4'b1001:          return !e.zero;
            4'b1100, 4'b1110: return e.cmp;
            4'b1101, 4'b1111: return !e.cmp;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic bit redirects(ent_t e);
        return e.trap || e.jump || takes_branch(e);
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_model();
        ent_t h;
        chk("ready", 64'(o_ready), 64'(q.size() < DEPTH));
        chk("valid", 64'(o_valid), 64'(q.size() != 0));
        chk("count", 64'(o_count), 64'(q.size()));
        if (q.size() != 0) begin
            h = q[0];
            chk("upc",      64'(o_upc),      64'(h.upc));
            chk("result",   64'(o_result),   64'(h.result));
            chk("rd",       64'(o_reg_rd),   64'(h.rd));
            chk("result_t", 64'(o_result_t), 64'(h.result_t));
            chk("reg_wen",  64'(o_reg_wen),  64'(h.reg_wen));
            chk("csr_wen",  64'(o_csr_wen),  64'(h.csr_wen));
            chk("jump",     64'(o_jump),     64'(redirects(h)));
        end else begin
            chk("idle_reg_wen", 64'(o_reg_wen), 64'(0));
            chk("idle_csr_wen", 64'(o_csr_wen), 64'(0));
            chk("idle_jump",    64'(o_jump),    64'(0));
        end
    endtask

    // Apply the queue rules for the inputs currently driven to the model.
    task automatic model_update();
        ent_t e;
        bit   acc, pop, redir;
        e.alu_t = i_alu_t;  e.rd = i_reg_rd;   e.cmp = i_cmp;     e.zero = i_zero;
        e.result_t = i_result_t; e.reg_wen = i_reg_wen; e.csr_wen = i_csr_wen;
        e.jump = i_jump;    e.trap = i_trap;   e.result = i_result; e.upc = i_upc;
        if (i_flush) begin
            q.delete();
        end else begin
            acc   = i_valid && (q.size() < DEPTH);
            pop   = (q.size() != 0) && i_ready;
            redir = pop && redirects(q[0]);
            if (redir) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (acc && !i_mem) q.push_back(e);
            end
        end
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic step();
        #1;
        check_model();
        model_update();
        @(negedge i_clock);
    endtask

    task automatic drive(bit v, logic [3:0] alu, logic [4:0] rd, bit cmp, bit zero,
                         bit jump, bit trap, bit wen, logic [31:0] upc,
                         logic [31:0] res, bit mem);
        i_valid = v;  i_alu_t = alu; i_reg_rd = rd; i_cmp = cmp; i_zero = zero;
        i_jump = jump; i_trap = trap; i_reg_wen = wen; i_upc = upc; i_result = res;
        i_mem = mem;  i_result_t = 1'b0; i_csr_wen = 1'b0;
    endtask

    task automatic idle();
        drive(0, 4'b0000, 5'd0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
    endtask

    task automatic alu_entry(logic [31:0] upc);
        drive(1, 4'b0000, 5'd1, 0, 0, 0, 0, 1, upc, upc + 32'h1, 0);
    endtask

    logic [3:0] br_codes [6] = '{4'b1000, 4'b1001, 4'b1100, 4'b1101, 4'b1110, 4'b1111};

    initial begin
        i_reset_n = 1'b0;
        i_ready   = 1'b0;
        i_flush   = 1'b0;
        idle();
        #2;
        chk("rst_valid",   64'(o_valid),   64'(0));
        chk("rst_ready",   64'(o_ready),   64'(1));
        chk("rst_count",   64'(o_count),   64'(0));
        chk("rst_jump",    64'(o_jump),    64'(0));
        chk("rst_reg_wen", 64'(o_reg_wen), 64'(0));
        chk("rst_csr_wen", 64'(o_csr_wen), 64'(0));
        @(negedge i_clock);
        i_reset_n = 1'b1;

        // single pass
        drive(1, 4'b0000, 5'd3, 0, 0, 0, 0, 1, 32'h8000_0010, 32'h5, 0);
        step();
        chk("sp_valid",  64'(o_valid),  64'(1));
        chk("sp_upc",    64'(o_upc),    64'h8000_0010);
        chk("sp_result", 64'(o_result), 64'h5);
        chk("sp_rd",     64'(o_reg_rd), 64'(3));
        chk("sp_jump",   64'(o_jump),   64'(0));
        idle();
        i_ready = 1'b1;
        step();
        chk("sp_count", 64'(o_count), 64'(0));

        // backpressure
        i_ready = 1'b0;
        alu_entry(32'h100); step();
        alu_entry(32'h104); step();
        chk("bp_ready", 64'(o_ready), 64'(0));
        chk("bp_count", 64'(o_count), 64'(2));
        alu_entry(32'h108); step();
        chk("bp_held_count", 64'(o_count), 64'(2));
        chk("bp_held_head",  64'(o_upc),   64'h100);
        i_ready = 1'b1;
        step();
        chk("bp_pop1_head",  64'(o_upc),   64'h104);
        chk("bp_pop1_count", 64'(o_count), 64'(1));
        step();
        chk("bp_pop2_head",  64'(o_upc),   64'h108);
        chk("bp_pop2_count", 64'(o_count), 64'(1));
        idle();
        step();
        chk("bp_drain", 64'(o_count), 64'(0));

        // branch decode
        i_ready = 1'b0;
        drive(1, 4'b1001, 5'd2, 0, 0, 0, 0, 0, 32'h300, 32'h0, 0); step();
        chk("br_bne_taken", 64'(o_jump), 64'(1));
        idle(); i_flush = 1'b1; step(); i_flush = 1'b0;
        drive(1, 4'b1101, 5'd2, 1, 0, 0, 0, 0, 32'h304, 32'h0, 0); step();
        chk("br_bge_not", 64'(o_jump), 64'(0));
        idle(); i_flush = 1'b1; step(); i_flush = 1'b0;
        drive(1, 4'b0000, 5'd2, 0, 0, 0, 0, 0, 32'h308, 32'h0, 0); step();
        chk("br_alu_not", 64'(o_jump), 64'(0));
        idle(); i_flush = 1'b1; step(); i_flush = 1'b0;

        // redirect squash
        drive(1, 4'b1000, 5'd0, 0, 1, 0, 0, 0, 32'h200, 32'h0, 0); step();
        alu_entry(32'h204); step();
        chk("rd_full", 64'(o_count), 64'(2));
        alu_entry(32'h208);
        i_ready = 1'b1;
        step();
        chk("rd_count", 64'(o_count), 64'(0));
        chk("rd_valid", 64'(o_valid), 64'(0));
        i_ready = 1'b0;
        drive(1, 4'b1000, 5'd0, 0, 1, 0, 0, 0, 32'h210, 32'h0, 0); step();
        alu_entry(32'h214);
        i_ready = 1'b1;
        step();
        chk("rd_acc_count", 64'(o_count), 64'(0));
        idle();
        i_ready = 1'b0;

        // memory skip
        drive(1, 4'b0000, 5'd4, 0, 0, 0, 0, 1, 32'h400, 32'h0, 1);
        #1;
        chk("ms_ready", 64'(o_ready), 64'(1));
        step();
        chk("ms_count", 64'(o_count), 64'(0));
        chk("ms_valid", 64'(o_valid), 64'(0));

        // flush beats accept
        alu_entry(32'h500); step();
        alu_entry(32'h504); step();
        i_ready = 1'b1;
        alu_entry(32'h508);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        chk("fl_count", 64'(o_count), 64'(0));
        chk("fl_valid", 64'(o_valid), 64'(0));

        // asynchronous reset mid-cycle
        i_ready = 1'b0;
        alu_entry(32'h600); step();
        idle();
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("ar_valid", 64'(o_valid), 64'(0));
        chk("ar_count", 64'(o_count), 64'(0));
        chk("ar_ready", 64'(o_ready), 64'(1));
        i_reset_n = 1'b1;
        q.delete();
        @(negedge i_clock);
        alu_entry(32'h604); step();
        chk("ar_accept", 64'(o_valid), 64'(1));
        chk("ar_head",   64'(o_upc),   64'h604);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(99) == 0) begin
                i_reset_n = 1'b0;
                #1;
                chk("rr_valid", 64'(o_valid), 64'(0));
                chk("rr_count", 64'(o_count), 64'(0));
                i_reset_n = 1'b1;
                q.delete();
            end
            i_valid    = ($urandom_range(9) < 7);
            i_ready    = $urandom_range(1) == 1;
            i_mem      = ($urandom_range(99) < 15);
            i_flush    = ($urandom_range(99) < 3);
            i_jump     = ($urandom_range(99) < 10);
            i_trap     = ($urandom_range(99) < 5);
            i_alu_t    = ($urandom_range(1) == 1) ? br_codes[$urandom_range(5)] : 4'($urandom);
            i_cmp      = $urandom_range(1) == 1;
            i_zero     = $urandom_range(1) == 1;
            i_result_t = $urandom_range(1) == 1;
            i_reg_wen  = $urandom_range(1) == 1;
            i_csr_wen  = $urandom_range(1) == 1;
            i_reg_rd   = 5'($urandom);
            i_result   = $urandom;
            i_upc      = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_24110006_exu_commit.md
YSYX_24110006_EXU_COMMIT -- requirements
Module: ysyx_24110006_exu_commit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width of result and upc.
REQ-002 SHALL have parameter RD_W, default 5, meaning destination register index width.
REQ-003 SHALL have parameter DEPTH, default 2, meaning entry queue depth, power of two, at least 2.
REQ-004 SHALL have port i_clock, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_reset_n, input, 1 bit, meaning reset: asynchronous and active-low.
REQ-006 SHALL have ports i_alu_t (4), i_reg_rd (RD_W), i_cmp, i_zero, i_result_t, i_reg_wen, i_csr_wen, i_jump, i_trap, i_mem (1 each), all inputs, meaning the execute-stage entry fields; i_mem marks a load/store owned by the LSU.
REQ-007 SHALL have ports i_result and i_upc, inputs, XLEN bits each, meaning the ALU result and the update PC.
REQ-008 SHALL have ports i_valid (input, 1) and o_ready (output, 1), meaning the upstream handshake.
REQ-009 SHALL have ports o_valid (output, 1) and i_ready (input, 1), meaning the downstream handshake.
REQ-010 SHALL have port i_flush, input, 1 bit, meaning external pipeline kill.
REQ-011 SHALL have outputs o_upc and o_result (XLEN), o_reg_rd (RD_W), and o_result_t, o_reg_wen, o_csr_wen, o_jump (1 each), meaning the head-entry fields.
REQ-012 SHALL have output o_count, $clog2(DEPTH)+1 bits, meaning the number of stored entries.

Function
REQ-013 SHALL accept on accept = i_valid && o_ready && !i_flush; o_ready = (count < DEPTH), with no combinational path from i_ready.
REQ-014 SHALL store an accepted entry with i_mem=0 at the tail; an accepted entry with i_mem=1 SHALL complete the handshake but not be stored.
REQ-015 SHALL drive o_valid = (count != 0); head pop = o_valid && i_ready.
REQ-016 SHALL present the head entry on outputs combinationally, with first-in first-out ordering.
REQ-017 SHALL compute branch on the head from its stored alu_t/zero/cmp: BEQ 4'b1000 && zero; BNE 4'b1001 && !zero; BLT 4'b1100 or BLTU 4'b1110 && cmp; BGE 4'b1101 or BGEU 4'b1111 && !cmp; any other alu_t gives 0.
REQ-018 SHALL drive o_jump = o_valid && (trap || jump || branch) for the head.
REQ-019 SHALL force o_reg_wen, o_csr_wen and o_jump to 0 when o_valid=0; other outputs are don't-care then.
REQ-020 SHALL add zero latency when empty: an entry accepted at edge N is on outputs with o_valid=1 after edge N.
REQ-021 SHALL permit simultaneous accept and pop when full: o_ready=0, so only the pop occurs that cycle.
REQ-022 SHALL permit simultaneous accept and pop when neither empty nor full: count is unchanged and order is preserved.
REQ-023 SHALL treat a pop with o_jump=1 as a redirect: all remaining entries and any same-cycle accepted entry are discarded, leaving count 0 after the edge.
REQ-024 SHALL, on i_flush=1, set count to 0 at the next edge; flush has priority over accept, pop and redirect.
REQ-025 SHALL wrap head and tail pointers modulo DEPTH, with no bubble at wrap.
REQ-026 SHALL never let count exceed DEPTH or underflow below 0.

Reset
REQ-027 SHALL, while i_reset_n=0, immediately clear count and the head/tail pointers, giving o_valid=0, o_ready=1, o_count=0, o_jump=0, o_reg_wen=0 and o_csr_wen=0.
REQ-028 SHALL not reset entry payload storage.
REQ-029 SHALL, on reset asserted mid-operation, drop all entries, and SHALL accept on the first rising edge after deassertion.

Verification
REQ-030 SHALL verify single pass: empty queue, i_valid=1 with i_upc=32'h8000_0010, i_result=32'h5, i_reg_rd=5'd3, i_reg_wen=1 -> next cycle o_valid=1, o_upc=32'h8000_0010, o_reg_rd=3, o_jump=0; with i_ready=1 -> o_count=0 afterwards.
REQ-031 SHALL verify backpressure: DEPTH=2, i_ready=0, three valid beats -> o_ready=0 after two; the third is held; entries pop in order once i_ready=1.
REQ-032 SHALL verify branch decode: head alu_t=4'b1001 with zero=0 -> o_jump=1; alu_t=4'b1101 with cmp=1 -> o_jump=0; alu_t=4'b0000 with jump=0 and trap=0 -> o_jump=0.
REQ-033 SHALL verify redirect squash: queue holds BEQ with zero=1 then an ALU op, plus a simultaneous accept; pop the head -> o_count=0 and o_valid=0 next cycle.
REQ-034 SHALL verify memory skip: i_valid=1 with i_mem=1 -> handshake completes, o_count stays 0, o_valid stays 0.
REQ-035 SHALL verify flush and reset: two entries plus i_flush=1 with i_valid=1 -> count 0, nothing accepted; i_reset_n pulsed low mid-cycle -> o_valid=0 without waiting for a clock edge.
